// File: rtl/ram_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module : ram_pkg
// Brief  : Shared widths, word/address types and rw encoding for ram_16x16.
// Rev    : 1.0  initial release
// ----------------------------------------------------------------------------
package ram_pkg;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 4;
  localparam int DEPTH  = 2 ** ADDR_W;

  typedef logic [DATA_W-1:0] word_t;
  typedef logic [ADDR_W-1:0] addr_t;

  // rw pin encoding
  localparam logic RW_WRITE = 1'b0;
  localparam logic RW_READ  = 1'b1;

endpackage : ram_pkg
`default_nettype wire

// File: rtl/ram_16x16_array.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module : ram_16x16_array
// Brief  : 16 x 16-bit register storage. Asynchronous clear to zero, one
//          synchronous write port and an unregistered indexed read.
// Rev    : 1.0  initial release
// ----------------------------------------------------------------------------
module ram_16x16_array
  import ram_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  wr_en,
  input  addr_t waddr,
  input  word_t wdata,
  input  addr_t raddr,
  output word_t rdata
);

  word_t mem_q [DEPTH];
  word_t mem_d [DEPTH];

  // Next-state of the array: only the addressed word changes on a write
  always_comb begin
    mem_d = mem_q;
    if (wr_en) begin
      mem_d[waddr] = wdata;
    end
  end

  // Storage flops; reset clears every word without waiting for a clock edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q <= '{default: '0};
    end else begin
      mem_q <= mem_d;
    end
  end

  // Read mux; the top registers this, so Q never sees a combinational path
  assign rdata = mem_q[raddr];

endmodule : ram_16x16_array
`default_nettype wire

// File: rtl/ram_16x16.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module : ram_16x16
// Brief  : Single-port 16-word x 16-bit data memory with registered read data.
//          en gates every access; rw selects write (0) or read (1).
// Config : RAM_WRITE_THROUGH_EN - when defined, a write also loads Q with the
//          written data on the same edge. Undefined: writes leave Q unchanged.
// Rev    : 1.0  initial release
// ----------------------------------------------------------------------------
module ram_16x16
  import ram_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  word_t A,
  input  addr_t addr,
  input  logic  en,
  input  logic  rw,
  output word_t Q
);

  logic  wr_en;
  logic  rd_en;
  word_t rd_data;
  word_t q_d;
  word_t q_q;

  // Access decode: rw only matters while en is asserted
  always_comb begin
    wr_en = en && (rw == RW_WRITE);
    rd_en = en && (rw == RW_READ);
  end

  ram_16x16_array u_array (
    .clk   (clk),
    .rst   (rst),
    .wr_en (wr_en),
    .waddr (addr),
    .wdata (A),
    .raddr (addr),
    .rdata (rd_data)
  );

  // Output data next-state: load on read (and on write when write-through)
  always_comb begin
    q_d = q_q;
    if (rd_en) begin
      q_d = rd_data;
    end
`ifdef RAM_WRITE_THROUGH_EN
    else if (wr_en) begin
      q_d = A;
    end
`endif
  end

  // Output data register, cleared asynchronously with the array
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign Q = q_q;

endmodule : ram_16x16
`default_nettype wire

// File: tb/tb_ram_16x16.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module : tb_ram_16x16
// Brief  : Self-checking bench for ram_16x16: directed scenarios followed by
//          random traffic, compared against an array-based memory model.
// Rev    : 1.0  initial release
// ----------------------------------------------------------------------------
module tb_ram_16x16;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] A;
  logic [3:0]  addr;
  logic        en;
  logic        rw;
  logic [15:0] Q;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: sixteen words plus the last value presented on Q
  logic [15:0] mem_m [16];
  logic [15:0] q_m;

  ram_16x16 dut (
    .clk  (clk),
    .rst  (rst),
    .A    (A),
    .addr (addr),
    .en   (en),
    .rw   (rw),
    .Q    (Q)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%04h expected=0x%04h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 16; i++) mem_m[i] = 16'h0000;
    q_m = 16'h0000;
  endtask

  // One clock of stimulus, entered and left at a falling edge; Q checked 1 unit after the rising edge
  task automatic do_op(input logic e, input logic r, input logic [3:0] a,
                       input logic [15:0] d, input string tag);
    en = e; rw = r; addr = a; A = d;
    @(posedge clk);
    if (e) begin
      if (r == 1'b0) begin
        mem_m[a] = d;
`ifdef RAM_WRITE_THROUGH_EN
        q_m = d;
`endif
      end else begin
        q_m = mem_m[a];
      end
    end
    #1;
    check_val(tag, Q, q_m);
    @(negedge clk);
  endtask

  task automatic wr(input logic [3:0] a, input logic [15:0] d, input string tag);
    do_op(1'b1, 1'b0, a, d, tag);
  endtask

  task automatic rd(input logic [3:0] a, input string tag);
    do_op(1'b1, 1'b1, a, 16'h0000, tag);
  endtask

  // Mid-cycle reset pulse held across one rising edge carrying a write that must be ignored
  task automatic reset_pulse(input string tag);
    #2;
    rst = 1'b1;
    model_clear();
    #1;
    check_val(tag, Q, 16'h0000);
    en = 1'b1; rw = 1'b0; addr = 4'h0; A = 16'hFFFF;
    @(posedge clk);
    #1;
    check_val({tag, "_held"}, Q, 16'h0000);
    @(negedge clk);
    rst = 1'b0;
    en  = 1'b0;
  endtask

  initial begin
    logic [15:0] q_before;
    rst = 1'b1; en = 1'b0; rw = 1'b0; addr = '0; A = '0;
    model_clear();
    #1;
    check_val("por_q", Q, 16'h0000);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // 1: load something nonzero, pulse reset mid-cycle, then sweep all words
    wr(4'h5, 16'h1111, "pre_wr5");
    rd(4'h5, "pre_rd5");
    @(posedge clk);
    reset_pulse("rst_async");
    for (int i = 0; i < 16; i++) rd(4'(i), "rst_sweep");

    // 2: three writes then reads in a different order
    wr(4'h0, 16'hABCD, "t2_wr0");
    wr(4'h1, 16'hFFEE, "t2_wr1");
    wr(4'h4, 16'hEEEE, "t2_wr4");
    rd(4'h1, "t2_rd1");
    check_val("t2_val1", Q, 16'hFFEE);
    rd(4'h0, "t2_rd0");
    check_val("t2_val0", Q, 16'hABCD);
    rd(4'h4, "t2_rd4");
    check_val("t2_val4", Q, 16'hEEEE);

    // 3: idle cycles with write-looking inputs leave Q and memory alone
    for (int i = 0; i < 4; i++) do_op(1'b0, 1'b0, 4'h0, 16'h0000, "t3_idle");
    check_val("t3_hold", Q, 16'hEEEE);
    rd(4'h0, "t3_rd0");
    check_val("t3_mem0", Q, 16'hABCD);

    // 4: top address, back-to-back write then read, neighbour untouched
    wr(4'hF, 16'h1234, "t4_wrF");
    rd(4'hF, "t4_rdF");
    check_val("t4_valF", Q, 16'h1234);
    rd(4'hE, "t4_rdE");
    check_val("t4_valE", Q, 16'h0000);

    // 5: reset wipes a freshly written word
    wr(4'h2, 16'h5A5A, "t5_wr2");
    reset_pulse("t5_rst");
    rd(4'h2, "t5_rd2");
    check_val("t5_val2", Q, 16'h0000);

    // 6: write behaviour on Q depends on the build
    rd(4'hF, "t6_prime");
    q_before = Q;
    wr(4'h3, 16'hBEEF, "t6_wr3");
`ifdef RAM_WRITE_THROUGH_EN
    check_val("t6_wt", Q, 16'hBEEF);
`else
    check_val("t6_nowt", Q, q_before);
`endif
    rd(4'h3, "t6_rd3");
    check_val("t6_val3", Q, 16'hBEEF);

    // Random traffic: mixed writes, reads and idles with random rw/addr/data
    for (int i = 0; i < 400; i++) begin
      do_op(1'($urandom_range(0, 3) != 0), 1'($urandom), 4'($urandom), 16'($urandom), "rand");
    end

    // Final sweep against the model
    for (int i = 0; i < 16; i++) rd(4'(i), "final_sweep");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_ram_16x16
`default_nettype wire
